// File: rtl/mult_div_iter.sv
// mult_div_iter: iterative MULT/MULTU/DIV/DIVU unit beside the EX stage.
// Result {hi,lo}: product, or {remainder, quotient} for divides.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   start, flush      request level from EX / cancel the op in flight
//   op                00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_1/2       multiplicand / dividend, multiplier / divisor
//   busy, done        in MUL/DIV states / one-cycle pulse in DONE
//   div_by_zero       divide with zero divisor, valid with done
//   result            2*WIDTH result, held until the next accepted start
//
// Optional: define MULT_DIV_FAST_MUL_EN for a single-cycle multiply.
module mult_div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               flush,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   operand_1,
    input  logic [WIDTH-1:0]   operand_2,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    // acc: running hi half of the product, or the partial remainder.
    // qlo: multiplier shifting out / dividend shifting out, quotient in.
    // opb: multiplicand or divisor (absolute value for signed ops).
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   qlo;
    logic [WIDTH-1:0]   opb;
    logic               neg_res;
    logic               neg_rem;
    logic               divz;

    logic               sgn_op;
    logic               last;
    logic [WIDTH-1:0]   abs_1;
    logic [WIDTH-1:0]   abs_2;

    logic [2*WIDTH-1:0] mul_prod;
    logic [2*WIDTH-1:0] mul_res;
`ifndef MULT_DIV_FAST_MUL_EN
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_acc_nxt;
    logic [WIDTH-1:0]   mul_lo_nxt;
`endif

    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_acc_nxt;
    logic [WIDTH-1:0]   div_lo_nxt;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dz_rem;

    assign busy = (state == S_MUL) || (state == S_DIV);
    assign done = (state == S_DONE);

    assign sgn_op = ~op[0];
    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign abs_1  = (sgn_op && operand_1[WIDTH-1]) ? -operand_1 : operand_1;
    assign abs_2  = (sgn_op && operand_2[WIDTH-1]) ? -operand_2 : operand_2;

`ifdef MULT_DIV_FAST_MUL_EN
    assign mul_prod = {{WIDTH{1'b0}}, opb} * {{WIDTH{1'b0}}, qlo};
`else
    // One shift-add step: add multiplicand into hi when the current
    // multiplier bit is set, then shift {hi, lo} right by one.
    assign mul_sum     = {1'b0, acc} + (qlo[0] ? {1'b0, opb} : '0);
    assign mul_acc_nxt = mul_sum[WIDTH:1];
    assign mul_lo_nxt  = {mul_sum[0], qlo[WIDTH-1:1]};
    assign mul_prod    = {mul_acc_nxt, mul_lo_nxt};
`endif

    assign mul_res = neg_res ? -mul_prod : mul_prod;

    // Restoring step on a WIDTH+1 bit shifted remainder. The remainder
    // kept between steps is always below the divisor, so WIDTH bits
    // hold it and the subtraction can be done modulo 2^WIDTH.
    assign div_shift   = {acc, qlo[WIDTH-1]};
    assign div_ge      = div_shift >= {1'b0, opb};
    assign div_diff    = div_shift[WIDTH-1:0] - opb;
    assign div_acc_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
    assign div_lo_nxt  = {qlo[WIDTH-2:0], div_ge};

    assign quot = neg_res ? -div_lo_nxt : div_lo_nxt;
    assign rem  = neg_rem ? -div_acc_nxt : div_acc_nxt;
    // Re-applying the dividend sign to its magnitude restores the raw
    // operand_1, including the most negative value.
    assign dz_rem = neg_rem ? -qlo : qlo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc         <= '0;
            qlo         <= '0;
            opb         <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            divz        <= 1'b0;
            div_by_zero <= 1'b0;
            result      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        cnt         <= '0;
                        acc         <= '0;
                        qlo         <= abs_1;
                        opb         <= abs_2;
                        neg_res     <= sgn_op &&
                                       (operand_1[WIDTH-1] ^ operand_2[WIDTH-1]);
                        neg_rem     <= sgn_op && operand_1[WIDTH-1];
                        divz        <= op[1] && (operand_2 == '0);
                        div_by_zero <= 1'b0;
                        state       <= op[1] ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
`ifdef MULT_DIV_FAST_MUL_EN
                        result <= mul_res;
                        state  <= S_DONE;
`else
                        acc <= mul_acc_nxt;
                        qlo <= mul_lo_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (last) begin
                            result <= mul_res;
                            state  <= S_DONE;
                        end
`endif
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (divz) begin
                        result      <= {dz_rem, {WIDTH{1'b1}}};
                        div_by_zero <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        acc <= div_acc_nxt;
                        qlo <= div_lo_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (last) begin
                            result <= {rem, quot};
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Already committed: flush does not suppress done.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_iter.sv
// tb_mult_div_iter: directed and random checks of mult_div_iter
// against a plain-arithmetic reference model (WIDTH = 32).
module tb_mult_div_iter;

    localparam int W = 32;
`ifdef MULT_DIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           flush = 1'b0;
    logic [1:0]     op = 2'b00;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic           dz;
    logic [2*W-1:0] result;

    int vectors = 0;
    int miscompares = 0;

    mult_div_iter #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .flush(flush),
        .op(op),
        .operand_1(a),
        .operand_2(b),
        .busy(busy),
        .done(done),
        .div_by_zero(dz),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {div_by_zero, result} from the arithmetic definition.
    function automatic logic [64:0] model(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] qv;
        logic [63:0] rv;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        model = '0;
        case (o)
            2'b00: begin
                p = sx * sy;
                model = {1'b0, p};
            end
            2'b01: begin
                p = {32'h0, x} * {32'h0, y};
                model = {1'b0, p};
            end
            default: begin
                if (y == 32'h0) begin
                    model = {1'b1, x, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    q = sx / sy;
                    r = sx % sy;
                    qv = q;
                    rv = r;
                    model = {1'b0, rv[31:0], qv[31:0]};
                end else begin
                    p = {32'h0, x} / {32'h0, y};
                    qv = {32'h0, x} % {32'h0, y};
                    model = {1'b0, qv[31:0], p[31:0]};
                end
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
        if (!o[1]) return MUL_LAT;
        if (y == 32'h0) return 1;
        return W;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] c [5];
        c[0] = 32'h0;
        c[1] = 32'h1;
        c[2] = 32'hFFFF_FFFF;
        c[3] = 32'h8000_0000;
        c[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Present a request so it is accepted at the next edge; returns
    // #1 after that acceptance edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit hold);
        @(posedge clk);
        #1;
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // lat = number of edges after acceptance until done is visible.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= W + 10; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y);
        int          lat;
        logic [64:0] m;
        issue(o, x, y, 1'b0);
        wait_done(lat);
        m = model(o, x, y);
        chk({tag, ".lat"}, 64'(lat), 64'(exp_lat(o, y)));
        chk({tag, ".res"}, result, m[63:0]);
        chk({tag, ".dz"}, 64'(dz), 64'(m[64]));
    endtask

    int          lat;
    int          ndone;
    logic [63:0] prev;
    logic [64:0] m;
    logic [1:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;

    initial begin
        #12;
        chk("rst.busy", 64'(busy), 64'h0);
        chk("rst.done", 64'(done), 64'h0);
        chk("rst.dz", 64'(dz), 64'h0);
        chk("rst.result", result, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
        chk("mult_neg.val", result, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max.val", result, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        chk("div_neg.val", result, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_min", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_min.val", result, 64'h0000_0000_8000_0000);
        run_op("divu_zero", 2'b11, 32'h0000_0064, 32'h0);
        chk("divu_zero.val", result, 64'h0000_0064_FFFF_FFFF);
        chk("divu_zero.flag", 64'(dz), 64'h1);

        // Next accepted start clears div_by_zero.
        issue(2'b11, 32'd100, 32'd7, 1'b0);
        chk("dz_clear", 64'(dz), 64'h0);
        chk("busy_div", 64'(busy), 64'h1);
        wait_done(lat);
        chk("divu_100_7", result, 64'h0000_0002_0000_000E);

        // Flush mid-divide at edge N+10, restart at N+11.
        prev = result;
        issue(2'b11, 32'd100, 32'd3, 1'b0);
        ndone = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (done) ndone++;
        chk("flush.busy", 64'(busy), 64'h0);
        chk("flush.nodone", 64'(ndone), 64'h0);
        chk("flush.result", result, prev);
        op = 2'b11;
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        chk("flush.restart.lat", 64'(lat), 64'(W));
        chk("flush.restart.res", result, 64'h0000_0002_0000_000E);

        // Flush in IDLE suppresses acceptance.
        @(posedge clk);
        #1;
        op = 2'b00;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("idle_flush.busy", 64'(busy), 64'h0);

        // Start held high across the op, operands changed while busy.
        issue(2'b10, 32'hFFFF_FF00, 32'd9, 1'b1);
        op = 2'b01;
        a = $urandom;
        b = $urandom;
        wait_done(lat);
        start = 1'b0;
        m = model(2'b10, 32'hFFFF_FF00, 32'd9);
        chk("held.lat", 64'(lat), 64'(W));
        chk("held.res", result, m[63:0]);
        ndone = 0;
        repeat (W + 5) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("held.extra_done", 64'(ndone), 64'h0);

        // Async reset mid-multiply.
        issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.flags", {61'h0, busy, done, dz}, 64'h0);
        chk("midrst.result", result, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        repeat (W + 5) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("midrst.nodone", 64'(ndone), 64'h0);

        // Random ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = pick();
            ry = pick();
            run_op($sformatf("rnd%0d_op%0d", i, ro), ro, rx, ry);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_div_iter.md
Name: mult_div_iter

Overview:
- Parametrised iterative multiply/divide unit beside the EX stage.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Returns a 2*WIDTH {hi, lo} result for the HILO write.
- EX holds `start` and stalls until `done` pulses; generalises the fixed 32-bit mult_div interface with width, signed and unsigned modes, cancellation and divide-by-zero reporting.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request level from EX; sampled only in IDLE.
- flush  input  1  cancel the operation in flight (pipeline flush or exception).
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- operand_1  input  WIDTH  multiplicand / dividend; sampled with start.
- operand_2  input  WIDTH  multiplier / divisor; sampled with start.
- busy  output  1  high in MUL and DIV states.
- done  output  1  one-cycle pulse in the DONE state.
- div_by_zero  output  1  valid with done; high when a DIV or DIVU had divisor 0.
- result  output  2*WIDTH  product {hi,lo}, or {remainder, quotient}; held from DONE until the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, div_by_zero=0, result=0; counter and internal registers cleared. Reset mid-operation aborts with no done.
- States: IDLE, MUL, DIV, DONE.
  - IDLE: start=1 and flush=0 latches op and operands and goes to MUL or DIV; counter=0.
  - DIV with operand_2==0 goes straight to DONE next cycle.
  - start=0 stays in IDLE.
- Signed ops (MULT, DIV): latch absolute values plus sign bits. Unsigned ops latch raw values.
- MUL: radix-2 shift-add, one multiplier bit per cycle. WIDTH cycles, then DONE.
- DIV: restoring, one quotient bit per cycle on a (WIDTH+1)-bit partial remainder. WIDTH cycles, then DONE.
- Signed fix-up, applied on entry to DONE:
  - product negated if the signs differ;
  - quotient negated if the signs differ;
  - remainder takes the dividend's sign.
  - Arithmetic is two's-complement wrap: MIN/-1 gives quotient MIN, remainder 0. MIN*MIN is exact.
- Divide by zero: quotient all ones, remainder = operand_1 as-is (no sign fix-up), div_by_zero=1.
- Latency: start accepted at edge N.
  - done high during cycle N+WIDTH+1 (MUL/DIV).
  - done high during cycle N+2 for divide by zero.
- DONE: done=1 for exactly one cycle, result valid, then IDLE. The next start is honoured in the following IDLE cycle, so back-to-back ops have no extra gap beyond IDLE.
- start while busy or in DONE: ignored; operands and op are not re-sampled.
- flush:
  - in MUL/DIV: next state IDLE, no done, result keeps its previous value;
  - in DONE: done still pulses (already committed);
  - in IDLE: suppresses acceptance of start.
- div_by_zero clears on the next accepted start.

Optional Feature:
- Macro MULT_DIV_FAST_MUL_EN.
- Defined: MUL computes the full product combinationally from the latched operands in its single state cycle. MUL/MULTU done at cycle N+2; DIV timing unchanged.
- Undefined: iterative shift-add multiply, WIDTH cycles.

Test Plan (WIDTH=32):
- MULT 0xFFFFFFFE x 0x00000003 -> done at N+33, result 0xFFFFFFFF_FFFFFFFA, div_by_zero=0.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE_00000001. With MULT_DIV_FAST_MUL_EN defined, done at N+2.
- DIV 0xFFFFFFF9 / 0x00000002 -> result {0xFFFFFFFF, 0xFFFFFFFD}. DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- DIVU 0x00000064 / 0 -> done at N+2, div_by_zero=1, result {0x00000064, 0xFFFFFFFF}.
- DIVU 100/7, flush at cycle N+10 -> busy=0 at N+11, no done, result unchanged. New DIVU 100/7 started at N+11 -> done at N+44, result {0x00000002, 0x0000000E}.
- rst_n low mid-MULT -> all outputs 0 immediately. start held high across busy -> exactly one done per accepted start.
